// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: divides Clk by two into a pixel tick and runs
// 800x525 horizontal/vertical counters with registered sync/blank/coordinate outputs.
`timescale 1ns/1ps

module vga_sync_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        PixEn,
  output logic        VGA_Clk,
  output logic [10:0] Columna,
  output logic [10:0] Fila,
  output logic        Activo,
  output logic        Hsync,
  output logic        Vsync,
  output logic        VGA_blank,
  output logic        VGA_sync,
  output logic        LineStart,
  output logic        FrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic        div_q,         div_d;
  logic        pix_en_q,      pix_en_d;
  logic [10:0] hc_q,          hc_d;
  logic [10:0] vc_q,          vc_d;
  logic        activo_q,      activo_d;
  logic        hsync_q,       hsync_d;
  logic        vsync_q,       vsync_d;
  logic        line_start_q,  line_start_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    div_d         = ~div_q;
    pix_en_d      = div_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    activo_d      = activo_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 11'd1;
      end else begin
        hc_d = hc_q + 11'd1;
      end

      // NOTE: blocking assignments here, so the decodes below see the new hc_d/vc_d.
      activo_d      = (hc_d < H_VIS_W) && (vc_d < V_VIS_W);
      hsync_d       = (hc_d >= HS_FIRST && hc_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (vc_d >= VS_FIRST && vc_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (hc_d == '0);
      frame_start_d = (hc_d == '0) && (vc_d == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_q         <= 1'b0;
      pix_en_q      <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      activo_q      <= 1'b1;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      activo_q      <= activo_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign PixEn      = pix_en_q;
  assign VGA_Clk    = div_q;
  assign Columna    = hc_q;
  assign Fila       = vc_q;
  assign Activo     = activo_q;
  assign VGA_blank  = activo_q;
  assign Hsync      = hsync_q;
  assign Vsync      = vsync_q;
  assign VGA_sync   = 1'b0;
  assign LineStart  = line_start_q;
  assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a short-frame variant for the
// frame wrap / vertical sync window, and a positive-polarity variant.
`timescale 1ns/1ps

module tb_vga_sync_gen;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  // Default timing, negative polarity.
  logic        a_pe, a_vclk, a_act, a_hs, a_vs, a_blank, a_sync, a_ls, a_fs;
  logic [10:0] a_col, a_fila;
  // Short frame: 8 lines, VS window on lines 5..6.
  logic        v_pe, v_vclk, v_act, v_hs, v_vs, v_blank, v_sync, v_ls, v_fs;
  logic [10:0] v_col, v_fila;
  // Default timing, positive polarity.
  logic        p_pe, p_vclk, p_act, p_hs, p_vs, p_blank, p_sync, p_ls, p_fs;
  logic [10:0] p_col, p_fila;

  vga_sync_gen dut_a (
    .Clk(clk), .Rst(rst), .PixEn(a_pe), .VGA_Clk(a_vclk), .Columna(a_col), .Fila(a_fila),
    .Activo(a_act), .Hsync(a_hs), .Vsync(a_vs), .VGA_blank(a_blank), .VGA_sync(a_sync),
    .LineStart(a_ls), .FrameStart(a_fs)
  );

  vga_sync_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut_v (
    .Clk(clk), .Rst(rst), .PixEn(v_pe), .VGA_Clk(v_vclk), .Columna(v_col), .Fila(v_fila),
    .Activo(v_act), .Hsync(v_hs), .Vsync(v_vs), .VGA_blank(v_blank), .VGA_sync(v_sync),
    .LineStart(v_ls), .FrameStart(v_fs)
  );

  vga_sync_gen #(.SYNC_POL(1'b1)) dut_p (
    .Clk(clk), .Rst(rst), .PixEn(p_pe), .VGA_Clk(p_vclk), .Columna(p_col), .Fila(p_fila),
    .Activo(p_act), .Hsync(p_hs), .Vsync(p_vs), .VGA_blank(p_blank), .VGA_sync(p_sync),
    .LineStart(p_ls), .FrameStart(p_fs)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_col !== 11'd0)  begin n_err++; $display("FAIL reset_col got %0d exp 0", a_col); end
    n_cmp++; if (a_fila !== 11'd0) begin n_err++; $display("FAIL reset_fila got %0d exp 0", a_fila); end
    n_cmp++; if (a_act !== 1'b1)   begin n_err++; $display("FAIL reset_activo got %b exp 1", a_act); end
    n_cmp++; if (a_blank !== 1'b1) begin n_err++; $display("FAIL reset_blank got %b exp 1", a_blank); end
    n_cmp++; if (a_hs !== 1'b1)    begin n_err++; $display("FAIL reset_hsync got %b exp 1", a_hs); end
    n_cmp++; if (a_vs !== 1'b1)    begin n_err++; $display("FAIL reset_vsync got %b exp 1", a_vs); end
    n_cmp++; if (a_ls !== 1'b0)    begin n_err++; $display("FAIL reset_linestart got %b exp 0", a_ls); end
    n_cmp++; if (a_fs !== 1'b0)    begin n_err++; $display("FAIL reset_framestart got %b exp 0", a_fs); end
    n_cmp++; if (a_pe !== 1'b0)    begin n_err++; $display("FAIL reset_pixen got %b exp 0", a_pe); end
    n_cmp++; if (a_vclk !== 1'b0)  begin n_err++; $display("FAIL reset_vgaclk got %b exp 0", a_vclk); end
    n_cmp++; if (a_sync !== 1'b0)  begin n_err++; $display("FAIL reset_vgasync got %b exp 0", a_sync); end
    n_cmp++; if (p_hs !== 1'b0)    begin n_err++; $display("FAIL reset_pol_hsync got %b exp 0", p_hs); end
    n_cmp++; if (p_vs !== 1'b0)    begin n_err++; $display("FAIL reset_pol_vsync got %b exp 0", p_vs); end
  endtask

  // Releases reset at a falling edge and checks the first ticks after release.
  task automatic test_startup();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (a_pe !== ((k % 2) == 0)) begin
        n_err++; $display("FAIL startup_pixen k=%0d got %b exp %b", k, a_pe, (k % 2) == 0);
      end
      n_cmp++;
      if (a_col !== 11'((k - 1) / 2)) begin
        n_err++; $display("FAIL startup_col k=%0d got %0d exp %0d", k, a_col, (k - 1) / 2);
      end
      n_cmp++;
      if (a_vclk !== 1'((k % 2))) begin
        n_err++; $display("FAIL startup_vgaclk k=%0d got %b exp %b", k, a_vclk, k % 2);
      end
      n_cmp++;
      if (a_sync !== 1'b0) begin
        n_err++; $display("FAIL startup_vgasync k=%0d got %b exp 0", k, a_sync);
      end
    end
  endtask

  task automatic test_line();
    int found = 0;
    int hs_low = 0, hs_bad = 0, vs_bad = 0, act_bad = 0, ls_cnt = 0, ls_bad = 0, pol_bad = 0;
    int first_hs = -1, act_fall = -1;
    logic exp_act;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      @(negedge clk);
      if (a_ls === 1'b1) found = 1;
    end
    n_cmp++; if (found != 1) begin n_err++; $display("FAIL line_wait linestart got none exp pulse"); end
    for (int i = 1; i <= 1600; i++) begin
      @(negedge clk);
      exp_act = (a_col < 11'd640) && (a_fila < 11'd480);
      if (a_hs === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(a_col);
      end
      if (a_hs !== ((a_col >= 11'd656 && a_col <= 11'd751) ? 1'b0 : 1'b1)) hs_bad++;
      if (a_vs !== 1'b1) vs_bad++;
      if (a_act !== exp_act || a_blank !== exp_act) act_bad++;
      if (a_act === 1'b0 && act_fall < 0) act_fall = int'(a_col);
      if (a_ls === 1'b1) begin
        ls_cnt++;
        if (a_col !== 11'd0) ls_bad++;
      end
      if (p_hs !== ~a_hs || p_vs !== ~a_vs || p_col !== a_col || p_fila !== a_fila) pol_bad++;
    end
    n_cmp++; if (hs_low != 192)   begin n_err++; $display("FAIL line_hs_width got %0d exp 192", hs_low); end
    n_cmp++; if (first_hs != 656) begin n_err++; $display("FAIL line_hs_start got %0d exp 656", first_hs); end
    n_cmp++; if (hs_bad != 0)     begin n_err++; $display("FAIL line_hs_window got %0d exp 0", hs_bad); end
    n_cmp++; if (vs_bad != 0)     begin n_err++; $display("FAIL line_vs_idle got %0d exp 0", vs_bad); end
    n_cmp++; if (act_bad != 0)    begin n_err++; $display("FAIL line_activo got %0d exp 0", act_bad); end
    n_cmp++; if (act_fall != 640) begin n_err++; $display("FAIL line_act_fall got %0d exp 640", act_fall); end
    n_cmp++; if (ls_cnt != 1)     begin n_err++; $display("FAIL line_ls_count got %0d exp 1", ls_cnt); end
    n_cmp++; if (ls_bad != 0)     begin n_err++; $display("FAIL line_ls_col got %0d exp 0", ls_bad); end
    n_cmp++; if (a_ls !== 1'b1)   begin n_err++; $display("FAIL line_ls_period got %b exp 1", a_ls); end
    n_cmp++; if (a_col !== 11'd0) begin n_err++; $display("FAIL line_end_col got %0d exp 0", a_col); end
    n_cmp++; if (a_act !== 1'b1)  begin n_err++; $display("FAIL line_act_rise got %b exp 1", a_act); end
    n_cmp++; if (pol_bad != 0)    begin n_err++; $display("FAIL line_polarity got %0d exp 0", pol_bad); end
  endtask

  task automatic test_frame_wrap();
    int found = 0;
    int vs_low = 0, vs_bad = 0, act_bad = 0, fs_cnt = 0, col_max = 0, fila_max = 0;
    int prev_col = -1, prev_fila = -1;
    logic exp_act;
    for (int i = 0; i < 20000 && found == 0; i++) begin
      @(negedge clk);
      if (v_fs === 1'b1) found = 1;
    end
    n_cmp++; if (found != 1) begin n_err++; $display("FAIL frame_wait framestart got none exp pulse"); end
    for (int i = 1; i <= 12800; i++) begin
      @(negedge clk);
      if (i == 12799) begin prev_col = int'(v_col); prev_fila = int'(v_fila); end
      exp_act = (v_col < 11'd640) && (v_fila < 11'd4);
      if (v_vs === 1'b0) vs_low++;
      if (v_vs !== ((v_fila >= 11'd5 && v_fila <= 11'd6) ? 1'b0 : 1'b1)) vs_bad++;
      if (v_act !== exp_act) act_bad++;
      if (v_fs === 1'b1) fs_cnt++;
      if (int'(v_col) > col_max) col_max = int'(v_col);
      if (int'(v_fila) > fila_max) fila_max = int'(v_fila);
    end
    n_cmp++; if (vs_low != 3200)  begin n_err++; $display("FAIL frame_vs_width got %0d exp 3200", vs_low); end
    n_cmp++; if (vs_bad != 0)     begin n_err++; $display("FAIL frame_vs_window got %0d exp 0", vs_bad); end
    n_cmp++; if (act_bad != 0)    begin n_err++; $display("FAIL frame_activo got %0d exp 0", act_bad); end
    n_cmp++; if (fs_cnt != 1)     begin n_err++; $display("FAIL frame_fs_count got %0d exp 1", fs_cnt); end
    n_cmp++; if (col_max != 799)  begin n_err++; $display("FAIL frame_col_max got %0d exp 799", col_max); end
    n_cmp++; if (fila_max != 7)   begin n_err++; $display("FAIL frame_fila_max got %0d exp 7", fila_max); end
    n_cmp++; if (prev_col != 799 || prev_fila != 7) begin
      n_err++; $display("FAIL frame_pre_wrap got %0d/%0d exp 799/7", prev_col, prev_fila);
    end
    n_cmp++; if (v_col !== 11'd0 || v_fila !== 11'd0) begin
      n_err++; $display("FAIL frame_wrap_pos got %0d/%0d exp 0/0", v_col, v_fila);
    end
    n_cmp++; if ({v_fs, v_ls, v_act, v_hs, v_vs} !== 5'b11111) begin
      n_err++; $display("FAIL frame_wrap_flags got %b exp 11111", {v_fs, v_ls, v_act, v_hs, v_vs});
    end
  endtask

  task automatic test_async_reset();
    int found = 0;
    int hs_bad = 0, vs_bad = 0;
    for (int i = 0; i < 20000 && found == 0; i++) begin
      @(negedge clk);
      if (v_col === 11'd700 && v_fila === 11'd6) found = 1;
    end
    n_cmp++; if (found != 1) begin n_err++; $display("FAIL arst_wait got none exp col700/fila6"); end
    n_cmp++; if ({v_hs, v_vs} !== 2'b00) begin
      n_err++; $display("FAIL arst_pre_sync got %b exp 00", {v_hs, v_vs});
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (v_col !== 11'd0 || v_fila !== 11'd0) begin
      n_err++; $display("FAIL arst_pos got %0d/%0d exp 0/0", v_col, v_fila);
    end
    n_cmp++; if ({v_hs, v_vs, v_act, v_pe, v_ls, v_fs} !== 6'b111000) begin
      n_err++; $display("FAIL arst_flags got %b exp 111000", {v_hs, v_vs, v_act, v_pe, v_ls, v_fs});
    end
    n_cmp++; if ({p_hs, p_vs} !== 2'b00) begin
      n_err++; $display("FAIL arst_pol got %b exp 00", {p_hs, p_vs});
    end
    @(negedge clk);
    test_startup();
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (v_hs !== ((v_col >= 11'd656 && v_col <= 11'd751) ? 1'b0 : 1'b1)) hs_bad++;
      if (v_vs !== 1'b1) vs_bad++;
    end
    n_cmp++; if (hs_bad != 0) begin n_err++; $display("FAIL arst_hs_glitch got %0d exp 0", hs_bad); end
    n_cmp++; if (vs_bad != 0) begin n_err++; $display("FAIL arst_vs_glitch got %0d exp 0", vs_bad); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    test_reset();
    test_startup();
    test_line();
    test_frame_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
